// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - bit-serial N-bit adder sequencer around a single one-bit full-adder cell
//
// Purpose:
//   Latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per
//   cycle (LSB first) through a single full-adder cell. The cell's carry is
//   registered back into its carry input, and each sum bit is shifted into the
//   MSB of the result register, so after WIDTH cycles the result is aligned.
//
// Optional feature macro: APPROX_LSB_EN
//   When defined, the low APPROX_BITS bits are computed as a|b with the carry
//   forced to 0, and in_cin is ignored if APPROX_BITS > 0.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      operand handshake valid
//   in_ready   out  1      operand handshake ready
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in
//   out_valid  out  1      result handshake valid
//   out_ready  in   1      result handshake ready
//   sum        out  WIDTH  result, LSB = bit 0
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high while bits are being processed

module bsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (b & c) | (a & c);
endmodule

module bit_serial_adder_ctrl #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef APPROX_LSB_EN
  localparam bit APPROX_ON = (APPROX_BITS > 0);
`else
  // Exact build: the approximate path is compiled out; APPROX_BITS has no effect.
  localparam bit APPROX_ON = 1'b0 & (APPROX_BITS > 0);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic w_cell_s;
  logic w_cell_co;
  logic w_approx;
  logic w_sum_bit;
  logic w_carry_next;
  logic w_last;
  logic w_accept;

  bsa_full_adder u_cell (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .c  (r_carry),
    .s  (w_cell_s),
    .co (w_cell_co)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // r_cnt is the index of the bit currently at the cell inputs.
  assign w_approx = APPROX_ON && (int'(r_cnt) < APPROX_BITS);

  assign w_sum_bit    = w_approx ? (r_a[0] | r_b[0]) : w_cell_s;
  assign w_carry_next = w_approx ? 1'b0 : w_cell_co;

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Releasing the result frees the datapath, so a new operand pair can
        // be taken on the same edge.
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_carry <= APPROX_ON ? 1'b0 : in_cin;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
        r_carry <= w_carry_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) r_cout <= w_carry_next;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb/tb_bit_serial_adder_ctrl.sv - self-checking bench for bit_serial_adder_ctrl
module tb_bit_serial_adder_ctrl;

  localparam int W  = 8;
  localparam int AB = 2;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_vec;
  int n_err;

  bit_serial_adder_ctrl #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  // Reference: {cout,sum} as plain integer addition.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
`ifdef APPROX_LSB_EN
    logic [W:0] hi;
    logic [W-1:0] mask;
    mask = W'((1 << AB) - 1);
    hi = (W+1)'(a >> AB) + (W+1)'(b >> AB);
    return (W+1)'((hi << AB) | {1'b0, (a | b) & mask});
`else
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete add with out_ready high; returns result and clocks from
  // the accepting edge (counted as 1) to out_valid.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic co, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_add", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_in_run", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    s  = sum;
    co = cout;
  endtask

  vec_t         vt[8];
  logic [W-1:0] s;
  logic         co;
  logic [W:0]   m;
  int           lat;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vt[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
`ifdef APPROX_LSB_EN
    for (int i = 0; i < 8; i++) begin
      m = model(vt[i].a, vt[i].b, vt[i].cin);
      vt[i].exp_sum = m[W-1:0];
      vt[i].exp_cout = m[W];
    end
`endif

    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_add(vt[i].a, vt[i].b, vt[i].cin, s, co, lat);
      check("tbl_latency", lat, LAT);
      check("tbl_sum", {24'd0, s}, {24'd0, vt[i].exp_sum});
      check("tbl_cout", {31'd0, co}, {31'd0, vt[i].exp_cout});
    end

`ifdef APPROX_LSB_EN
    do_add(8'h03, 8'h01, 1'b1, s, co, lat);
    check("approx_sum", {24'd0, s}, 32'h03);
    check("approx_cout", {31'd0, co}, 32'd0);
`endif

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      m = model(ra, rb, rc);
      do_add(ra, rb, rc, s, co, lat);
      check("rnd_latency", lat, LAT);
      check("rnd_sum", {24'd0, s}, {24'd0, m[W-1:0]});
      check("rnd_cout", {31'd0, co}, {31'd0, m[W]});
    end

    // Result held under backpressure; operand pulses ignored meanwhile.
    tick();
    out_ready = 1'b0;
    do_add(8'hF0, 8'h20, 1'b1, s, co, lat);
    check("hold_first_sum", {24'd0, s}, 32'h11);
    check("hold_first_cout", {31'd0, co}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'h77; in_b = 8'h66; in_cin = 1'b1;
      tick();
      in_valid = 1'b0;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_sum", {24'd0, sum}, 32'h11);
      check("hold_cout", {31'd0, cout}, 32'd1);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("release_latency", lat, LAT);
    m = model(8'h12, 8'h34, 1'b0);
    check("release_sum", {24'd0, sum}, {24'd0, m[W-1:0]});

    // Reset on the 4th RUN cycle aborts the add.
    tick();
    in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    do_add(8'h80, 8'h80, 1'b0, s, co, lat);
    m = model(8'h80, 8'h80, 1'b0);
    check("post_abort_sum", {24'd0, s}, {24'd0, m[W-1:0]});
    check("post_abort_cout", {31'd0, co}, {31'd0, m[W]});

    // Back-to-back: in_valid and out_ready held high for four operations.
    begin
      logic [W:0]   exp_q[$];
      logic [W-1:0] opa[4];
      logic [W-1:0] opb[4];
      int nsent, nrecv, cyc, last_cyc;
      logic acc;
      for (int i = 0; i < 4; i++) begin
        opa[i] = W'($urandom); opb[i] = W'($urandom);
      end
      tick();
      nsent = 0; nrecv = 0; cyc = 0; last_cyc = -1;
      in_cin = 1'b0; in_a = opa[0]; in_b = opb[0]; in_valid = 1'b1;
      while (nrecv < 4 && cyc < 200) begin
        acc = in_valid && in_ready;
        tick();
        cyc++;
        if (acc) begin
          exp_q.push_back(model(opa[nsent], opb[nsent], 1'b0));
          nsent++;
          if (nsent < 4) begin
            in_a = opa[nsent]; in_b = opb[nsent];
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("b2b_unexpected_result", 32'd1, 32'd0);
          end else begin
            m = exp_q.pop_front();
            check("b2b_sum", {24'd0, sum}, {24'd0, m[W-1:0]});
            check("b2b_cout", {31'd0, cout}, {31'd0, m[W]});
          end
          if (last_cyc >= 0) check("b2b_interval", cyc - last_cyc, LAT);
          last_cyc = cyc;
          nrecv++;
        end
      end
      check("b2b_results_seen", nrecv, 4);
      in_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
